sap_controller_sequencer: RTL and testbench

- Controller-sequencer for the 8-bit SAP datapath. Sequences the 16x8 program memory, PC, MAR, IR, A, B, ALU and output register.
- Runs a six-state ring counter (T1..T6) and decodes the current T-state plus the IR opcode nibble into the 12-bit control word.
- Enters a halted state on HLT.
- Sits between the instruction register and every datapath load/enable strobe.

---
 rtl/sap_pkg.sv | 45 ++++
 rtl/sap_controller_sequencer_if.sv | 20 ++
 rtl/sap_ring_counter.sv | 24 ++
 rtl/sap_controller_sequencer.sv | 98 +++++++++
 tb/tb_sap_controller_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// sap_pkg: shared constants for the SAP controller-sequencer.
//   - opcode encodings (IR[7:4])
//   - one-hot T-state codes (bit0 = T1 .. bit5 = T6)
//   - bit positions inside the 12-bit control word
//   - CON_IDLE: every strobe at its inactive level
package sap_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // con = {Cp,Ep,Lm_barra,CE_barra,Li_barra,Ei_barra,La_barra,Ea,Su,Eu,Lb_barra,Lo_barra}
  localparam int CP   = 11;
  localparam int EP   = 10;
  localparam int LM_B = 9;
  localparam int CE_B = 8;
  localparam int LI_B = 7;
  localparam int EI_B = 6;
  localparam int LA_B = 5;
  localparam int EA   = 4;
  localparam int SU   = 3;
  localparam int EU   = 2;
  localparam int LB_B = 1;
  localparam int LO_B = 0;

  localparam logic [11:0] CON_IDLE = 12'h3E3;

  // Opcodes with a real execute sequence; everything else behaves as NOP.
  function automatic logic is_defined_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/sap_controller_sequencer_if.sv
// sap_controller_sequencer_if: instruction/step inputs and control outputs
// of the SAP controller-sequencer.
//   opcode  : IR[7:4]
//   run     : 1 = free-run, 0 = single-step
//   step    : advance one T-state while run = 0
//   con     : 12-bit control word
//   t_state : one-hot ring state
//   halted  : HLT has executed
// master = whoever drives the instruction/step side, slave = the sequencer.
interface sap_controller_sequencer_if;
  logic [3:0]  opcode;
  logic        run;
  logic        step;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        halted;

  modport master (output opcode, run, step, input con, t_state, halted);
  modport slave  (input opcode, run, step, output con, t_state, halted);
endinterface

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: 6-bit one-hot T-state ring.
//   clk       : rising-edge clock
//   clr_barra : synchronous active-low clear, forces T1
//   advance   : move to the next state this edge
//   load_t1   : with advance, jump back to T1 instead of rotating
//   t_state   : one-hot state, bit0 = T1
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       clr_barra,
  input  logic       advance,
  input  logic       load_t1,
  output logic [5:0] t_state
);

  always_ff @(posedge clk) begin
    if (!clr_barra)
      t_state <= T1;
    else if (advance)
      t_state <= load_t1 ? T1 : {t_state[4:0], t_state[5]};
  end

endmodule

// File: rtl/sap_controller_sequencer.sv
// sap_controller_sequencer: SAP controller-sequencer.
//   clk       : rising-edge clock
//   clr_barra : synchronous active-low reset; also gates con to CON_IDLE
//   bus       : slave side of sap_controller_sequencer_if
//               (opcode/run/step in, con/t_state/halted out)
// Parameter SKIP_NOP = 1 returns to T1 right after the last non-idle
// execute state instead of always walking T1..T6.
module sap_controller_sequencer
  import sap_pkg::*;
#(
  parameter bit SKIP_NOP = 1'b0
) (
  input  logic                        clk,
  input  logic                        clr_barra,
  sap_controller_sequencer_if.slave   bus
);

  logic [5:0]  t_q;
  logic        halted_q;
  logic        go;
  logic        hlt_hit;
  logic        advance;
  logic        early;
  logic [11:0] con_dec;

  // HLT is recognised on the edge that would leave T4: the ring is frozen
  // there and halted is set instead of advancing.
  assign go      = (bus.run | bus.step) & ~halted_q;
  assign hlt_hit = t_q[3] && (bus.opcode == OP_HLT);
  assign advance = go & ~hlt_hit;

  // Early return to T1 after the last state that does useful work.
  assign early = SKIP_NOP &&
                 ((t_q[4] && (bus.opcode == OP_LDA)) ||
                  (t_q[3] && (bus.opcode == OP_OUT)) ||
                  (t_q[2] && !is_defined_op(bus.opcode)));

  sap_ring_counter u_ring (
    .clk       (clk),
    .clr_barra (clr_barra),
    .advance   (advance),
    .load_t1   (early),
    .t_state   (t_q)
  );

  always_ff @(posedge clk) begin
    if (!clr_barra)
      halted_q <= 1'b0;
    else if (go && hlt_hit)
      halted_q <= 1'b1;
  end

  // Decoder: start from the idle word and flip only the strobes each
  // state asserts.
  always_comb begin
    con_dec = CON_IDLE;
    if (!halted_q) begin
      case (t_q)
        T1: begin con_dec[EP] = 1'b1; con_dec[LM_B] = 1'b0; end
        T2: con_dec[CP] = 1'b1;
        T3: begin con_dec[CE_B] = 1'b0; con_dec[LI_B] = 1'b0; end
        T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              con_dec[EI_B] = 1'b0; con_dec[LM_B] = 1'b0;
            end
            OP_OUT: begin con_dec[EA] = 1'b1; con_dec[LO_B] = 1'b0; end
            default: ;
          endcase
        end
        T5: begin
          case (bus.opcode)
            OP_LDA: begin con_dec[CE_B] = 1'b0; con_dec[LA_B] = 1'b0; end
            OP_ADD, OP_SUB: begin
              con_dec[CE_B] = 1'b0; con_dec[LB_B] = 1'b0;
            end
            default: ;
          endcase
        end
        T6: begin
          case (bus.opcode)
            OP_ADD: begin con_dec[EU] = 1'b1; con_dec[LA_B] = 1'b0; end
            OP_SUB: begin
              con_dec[EU] = 1'b1; con_dec[LA_B] = 1'b0; con_dec[SU] = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.con     = clr_barra ? con_dec : CON_IDLE;
  assign bus.t_state = t_q;
  assign bus.halted  = halted_q;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
module tb_sap_controller_sequencer;

  typedef struct {
    logic [3:0]  op;
    logic        clr;
    logic        run;
    logic        step;
    logic [5:0]  t;
    logic [11:0] con;
    logic        halt;
  } exp_t;

  localparam logic [5:0] S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100,
                         S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000;

  logic clk = 1'b0;
  logic clr_barra;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  sap_controller_sequencer_if bus_m ();
  sap_controller_sequencer_if bus_s ();

  sap_controller_sequencer #(.SKIP_NOP(1'b0)) dut (
    .clk(clk), .clr_barra(clr_barra), .bus(bus_m));

  sap_controller_sequencer #(.SKIP_NOP(1'b1)) dut_skip (
    .clk(clk), .clr_barra(clr_barra), .bus(bus_s));

  task automatic push(input logic [3:0] op, input logic clr, input logic run,
                      input logic step, input logic [5:0] t,
                      input logic [11:0] con, input logic halt);
    exp_t x;
    x.op = op; x.clr = clr; x.run = run; x.step = step;
    x.t = t; x.con = con; x.halt = halt;
    sb.push_back(x);
  endtask

  task automatic push_fetch(input logic [3:0] op);
    push(op, 1, 1, 0, S1, 12'h5E3, 0);
    push(op, 1, 1, 0, S2, 12'hBE3, 0);
    push(op, 1, 1, 0, S3, 12'h263, 0);
  endtask

  task automatic push_instr(input logic [3:0] op, input logic [11:0] c4,
                            input logic [11:0] c5, input logic [11:0] c6);
    push_fetch(op);
    push(op, 1, 1, 0, S4, c4, 0);
    push(op, 1, 1, 0, S5, c5, 0);
    push(op, 1, 1, 0, S6, c6, 0);
  endtask

  task automatic do_reset(input logic run);
    clr_barra = 1'b0;
    bus_m.run = run; bus_m.step = 1'b0;
    bus_s.run = run; bus_s.step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int idx = 0;
    clr_barra = 1'b0;
    bus_m.opcode = 4'h0; bus_m.run = 1'b1; bus_m.step = 1'b0;
    @(posedge clk); #1;
    push(4'h0, 0, 1, 0, S1, 12'h3E3, 0);
    push(4'h0, 0, 1, 0, S1, 12'h3E3, 0);
    push_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
    push(4'h0, 1, 1, 0, S1, 12'h5E3, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      clr_barra = e.clr; bus_m.opcode = e.op; bus_m.run = e.run; bus_m.step = e.step;
      #1;
      n_checks++;
      if ({bus_m.t_state, bus_m.con, bus_m.halted} !== {e.t, e.con, e.halt}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got t=%b con=%h halted=%b, want t=%b con=%h halted=%b",
                 idx, bus_m.t_state, bus_m.con, bus_m.halted, e.t, e.con, e.halt);
      end
      @(posedge clk); #1;
      idx++;
    end
  endtask

  task automatic test_program();
    int idx = 0;
    do_reset(1'b1);
    push_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
    push_instr(4'h1, 12'h1A3, 12'h2E1, 12'h3C7);
    push_instr(4'h1, 12'h1A3, 12'h2E1, 12'h3C7);
    push_instr(4'h2, 12'h1A3, 12'h2E1, 12'h3CF);
    push_instr(4'hE, 12'h3F2, 12'h3E3, 12'h3E3);
    push_fetch(4'hF);
    push(4'hF, 1, 1, 0, S4, 12'h3E3, 0);
    // Frozen at T4 regardless of run/step activity.
    for (int i = 0; i < 10; i++)
      push(4'hF, 1, 1'(i % 2), 1'($urandom_range(0, 1)), S4, 12'h3E3, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      clr_barra = e.clr; bus_m.opcode = e.op; bus_m.run = e.run; bus_m.step = e.step;
      #1;
      n_checks++;
      if ({bus_m.t_state, bus_m.con, bus_m.halted} !== {e.t, e.con, e.halt}) begin
        n_fail++;
        $display("FAIL program[%0d]: got t=%b con=%h halted=%b, want t=%b con=%h halted=%b",
                 idx, bus_m.t_state, bus_m.con, bus_m.halted, e.t, e.con, e.halt);
      end
      @(posedge clk); #1;
      idx++;
    end
  endtask

  task automatic test_single_step();
    int idx = 0;
    do_reset(1'b0);
    push(4'h0, 1, 0, 0, S1, 12'h5E3, 0);
    push(4'h0, 1, 0, 0, S1, 12'h5E3, 0);
    push(4'h0, 1, 0, 1, S1, 12'h5E3, 0);
    push(4'h0, 1, 0, 0, S2, 12'hBE3, 0);
    push(4'h0, 1, 0, 0, S2, 12'hBE3, 0);
    push(4'h0, 1, 0, 1, S2, 12'hBE3, 0);
    push(4'h0, 1, 0, 0, S3, 12'h263, 0);
    push(4'h0, 1, 0, 1, S3, 12'h263, 0);
    push(4'h0, 1, 0, 0, S4, 12'h1A3, 0);
    // Step held for two cycles advances two states.
    push(4'h0, 1, 0, 1, S4, 12'h1A3, 0);
    push(4'h0, 1, 0, 1, S5, 12'h2C3, 0);
    push(4'h0, 1, 0, 0, S6, 12'h3E3, 0);
    push(4'h0, 1, 0, 0, S6, 12'h3E3, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      clr_barra = e.clr; bus_m.opcode = e.op; bus_m.run = e.run; bus_m.step = e.step;
      #1;
      n_checks++;
      if ({bus_m.t_state, bus_m.con, bus_m.halted} !== {e.t, e.con, e.halt}) begin
        n_fail++;
        $display("FAIL step[%0d]: got t=%b con=%h halted=%b, want t=%b con=%h halted=%b",
                 idx, bus_m.t_state, bus_m.con, bus_m.halted, e.t, e.con, e.halt);
      end
      @(posedge clk); #1;
      idx++;
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    do_reset(1'b1);
    push_fetch(4'h1);
    push(4'h1, 1, 1, 0, S4, 12'h1A3, 0);
    push(4'h1, 0, 1, 0, S5, 12'h3E3, 0);
    push_fetch(4'hF);
    push(4'hF, 1, 1, 0, S4, 12'h3E3, 0);
    push(4'hF, 1, 1, 0, S4, 12'h3E3, 1);
    push(4'hF, 1, 1, 1, S4, 12'h3E3, 1);
    push(4'hF, 0, 1, 0, S4, 12'h3E3, 1);
    push_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      clr_barra = e.clr; bus_m.opcode = e.op; bus_m.run = e.run; bus_m.step = e.step;
      #1;
      n_checks++;
      if ({bus_m.t_state, bus_m.con, bus_m.halted} !== {e.t, e.con, e.halt}) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got t=%b con=%h halted=%b, want t=%b con=%h halted=%b",
                 idx, bus_m.t_state, bus_m.con, bus_m.halted, e.t, e.con, e.halt);
      end
      @(posedge clk); #1;
      idx++;
    end
  endtask

  task automatic test_undefined_op();
    int idx = 0;
    do_reset(1'b1);
    push_instr(4'h7, 12'h3E3, 12'h3E3, 12'h3E3);
    push_instr(4'h3, 12'h3E3, 12'h3E3, 12'h3E3);
    push(4'h0, 1, 1, 0, S1, 12'h5E3, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      clr_barra = e.clr; bus_m.opcode = e.op; bus_m.run = e.run; bus_m.step = e.step;
      #1;
      n_checks++;
      if ({bus_m.t_state, bus_m.con, bus_m.halted} !== {e.t, e.con, e.halt}) begin
        n_fail++;
        $display("FAIL undef_op[%0d]: got t=%b con=%h halted=%b, want t=%b con=%h halted=%b",
                 idx, bus_m.t_state, bus_m.con, bus_m.halted, e.t, e.con, e.halt);
      end
      @(posedge clk); #1;
      idx++;
    end
  endtask

  task automatic test_skip_nop();
    int idx = 0;
    bus_m.run = 1'b0;
    do_reset(1'b1);
    bus_m.run = 1'b0;
    push_fetch(4'h0);                          // LDA: 5 states
    push(4'h0, 1, 1, 0, S4, 12'h1A3, 0);
    push(4'h0, 1, 1, 0, S5, 12'h2C3, 0);
    push_fetch(4'hE);                          // OUT: 4 states
    push(4'hE, 1, 1, 0, S4, 12'h3F2, 0);
    push_fetch(4'h7);                          // undefined: 3 states
    push_instr(4'h1, 12'h1A3, 12'h2E1, 12'h3C7); // ADD keeps 6 states
    push(4'h0, 1, 1, 0, S1, 12'h5E3, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      clr_barra = e.clr; bus_s.opcode = e.op; bus_s.run = e.run; bus_s.step = e.step;
      #1;
      n_checks++;
      if ({bus_s.t_state, bus_s.con, bus_s.halted} !== {e.t, e.con, e.halt}) begin
        n_fail++;
        $display("FAIL skip_nop[%0d]: got t=%b con=%h halted=%b, want t=%b con=%h halted=%b",
                 idx, bus_s.t_state, bus_s.con, bus_s.halted, e.t, e.con, e.halt);
      end
      @(posedge clk); #1;
      idx++;
    end
  endtask

  initial begin
    clr_barra = 1'b0;
    bus_m.opcode = 4'h0; bus_m.run = 1'b1; bus_m.step = 1'b0;
    bus_s.opcode = 4'h0; bus_s.run = 1'b1; bus_s.step = 1'b0;
    test_reset();
    test_program();
    test_single_step();
    test_reset_mid();
    test_undefined_op();
    test_skip_nop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
